// File: rtl/imem_arb_pkg.sv
// Shared constants and types for the instruction-memory s2 port arbiter.
// Port index 0 is the boot loader/DMA master, 1 is the debug master.
package imem_arb_pkg;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 4134;
    localparam int LOCK_MAX = 16;

    typedef logic port_idx_t;

    localparam port_idx_t PORT_M0 = 1'b0;
    localparam port_idx_t PORT_M1 = 1'b1;

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-way round-robin grant with lock ownership and lock timeout.
// Grant is combinational; history, lock owner and counter are registered.
module imem_rr_arb2
    import imem_arb_pkg::*;
#(
    parameter int LOCK_MAX = imem_arb_pkg::LOCK_MAX
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] lock_req,
    output logic       gnt_vld,
    output port_idx_t  gnt,
    output logic       lock_to
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    port_idx_t        last_grant;
    port_idx_t        owner;
    logic             locked;
    logic [CNT_W-1:0] lock_cnt;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = PORT_M0;
        if (locked) begin
            gnt     = owner;
            gnt_vld = req[owner];
        end else begin
            unique case (req)
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt     = PORT_M0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt     = PORT_M1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt     = ~last_grant;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt     = PORT_M0;
                end
            endcase
        end
    end

    // Final locked cycle: the owner's lock request is ignored this cycle.
    assign lock_to = locked && (lock_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= PORT_M1;
            owner      <= PORT_M0;
            locked     <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            if (gnt_vld) begin
                last_grant <= gnt;
            end
            if (locked) begin
                if (lock_to) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                end else if (gnt_vld && !lock_req[owner]) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end else if (gnt_vld && lock_req[gnt]) begin
                locked   <= 1'b1;
                owner    <= gnt;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction-memory s2 port between two Avalon-MM masters:
// request mux, range check, 1-cycle read return and sticky error flags.
module imem_port_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4134,
    parameter int LOCK_MAX = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    input  logic [DATA_W-1:0]     ram_readdata,

    input  logic                  err_clr,
    output logic                  err_oor,
    output logic                  err_lock_to
);

    import imem_arb_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [1:0]          req;
    logic [1:0]          lock_req;
    logic                gnt_vld;
    port_idx_t           gnt;
    logic                lock_to;

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W/8-1:0] sel_be;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_wr;
    logic                in_range;
    logic                accept_rd;
    logic                oor_hit;

    logic [1:0]          rd_vld;
    logic                rd_oor;

    // A write request takes precedence over a simultaneous read.
    assign req      = {m1_read | m1_write, m0_read | m0_write};
    assign lock_req = {m1_lock, m0_lock};

    imem_rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .lock_req (lock_req),
        .gnt_vld  (gnt_vld),
        .gnt      (gnt),
        .lock_to  (lock_to)
    );

    assign sel_addr  = (gnt == PORT_M1) ? m1_address    : m0_address;
    assign sel_be    = (gnt == PORT_M1) ? m1_byteenable : m0_byteenable;
    assign sel_wdata = (gnt == PORT_M1) ? m1_writedata  : m0_writedata;
    assign sel_wr    = (gnt == PORT_M1) ? m1_write      : m0_write;

    assign in_range  = {1'b0, sel_addr} < DEPTH_W;
    assign accept_rd = gnt_vld && !sel_wr;
    assign oor_hit   = gnt_vld && !in_range;

    assign m0_waitrequest = !(gnt_vld && (gnt == PORT_M0));
    assign m1_waitrequest = !(gnt_vld && (gnt == PORT_M1));

    // Out-of-range transfers are acknowledged but never reach the RAM.
    assign ram_address    = sel_addr;
    assign ram_byteenable = sel_be;
    assign ram_writedata  = sel_wdata;
    assign ram_chipselect = gnt_vld && in_range;
    assign ram_write      = ram_chipselect && sel_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld      <= 2'b00;
            rd_oor      <= 1'b0;
            err_oor     <= 1'b0;
            err_lock_to <= 1'b0;
        end else begin
            rd_vld[0] <= accept_rd && (gnt == PORT_M0);
            rd_vld[1] <= accept_rd && (gnt == PORT_M1);
            rd_oor    <= !in_range;
            if (oor_hit) begin
                err_oor <= 1'b1;
            end else if (err_clr) begin
                err_oor <= 1'b0;
            end
            if (lock_to) begin
                err_lock_to <= 1'b1;
            end else if (err_clr) begin
                err_lock_to <= 1'b0;
            end
        end
    end

    assign m0_readdatavalid = rd_vld[0];
    assign m1_readdatavalid = rd_vld[1];
    assign m0_readdata = (rd_vld[0] && !rd_oor) ? ram_readdata : '0;
    assign m1_readdata = (rd_vld[1] && !rd_oor) ? ram_readdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle RAM.
// Inputs change 1ns after posedge; outputs are sampled before the next edge.
module tb_imem_port_arbiter;

    logic        clk;
    logic        reset_n;

    logic [12:0] m0_address;
    logic [3:0]  m0_byteenable;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic        m0_lock;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;

    logic [12:0] m1_address;
    logic [3:0]  m1_byteenable;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic        m1_lock;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;

    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    logic        err_clr;
    logic        err_oor;
    logic        err_lock_to;

    int n_vec = 0;
    int n_err = 0;

    imem_port_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_lock          (m0_lock),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_lock          (m1_lock),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_readdata     (ram_readdata),
        .err_clr          (err_clr),
        .err_oor          (err_oor),
        .err_lock_to      (err_lock_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preloaded on the first edge, read data registered.
    logic [31:0] mem [0:8191];
    logic        preloaded = 1'b0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 32'h0;
            mem[5]    <= 32'hDEADBEEF;
            mem[100]  <= 32'hAAAAAAAA;
            mem[4133] <= 32'h0BADF00D;
            preloaded <= 1'b1;
        end else if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b])
                        mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_address = '0; m0_byteenable = 4'hF; m0_read = 0; m0_write = 0;
        m0_writedata = '0; m0_lock = 0;
        m1_address = '0; m1_byteenable = 4'hF; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_lock = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    int p0, p1;
    bit e0;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ram_readdata = '0;
        err_clr = 1'b0;
        idle();
        reset_n = 1'b0;
        repeat (3) step();
        chk("rst_rdv0", m0_readdatavalid, 0);
        chk("rst_rdv1", m1_readdatavalid, 0);
        chk("rst_rd0", m0_readdata, 0);
        chk("rst_oor", err_oor, 0);
        chk("rst_lto", err_lock_to, 0);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_wr", ram_write, 0);
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_wait1", m1_waitrequest, 1);
        reset_n = 1'b1;
        step();

        // Single read from m0
        m0_address = 13'd5; m0_read = 1;
        #1;
        chk("rd_wait0", m0_waitrequest, 0);
        chk("rd_wait1", m1_waitrequest, 1);
        chk("rd_cs", ram_chipselect, 1);
        chk("rd_addr", ram_address, 5);
        step();
        idle();
        chk("rd_rdv0", m0_readdatavalid, 1);
        chk("rd_data0", m0_readdata, 32'hDEADBEEF);
        chk("rd_rdv1", m1_readdatavalid, 0);
        step();
        chk("rd_rdv0_end", m0_readdatavalid, 0);
        chk("idle_cs", ram_chipselect, 0);

        // Both masters read continuously: strict alternation from reset
        do_reset();
        p0 = 0; p1 = 0;
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                e0 = ((i - 1) % 2 == 0);
                chk("alt_rdv0", m0_readdatavalid, e0);
                chk("alt_rdv1", m1_readdatavalid, !e0);
                if (e0) chk("alt_d0", m0_readdata, 32'hDEADBEEF);
                else    chk("alt_d1", m1_readdata, 32'hAAAAAAAA);
                p0 += int'(m0_readdatavalid);
                p1 += int'(m1_readdatavalid);
            end
            if (i < 6) begin
                m0_address = 13'd5;   m0_read = 1;
                m1_address = 13'd100; m1_read = 1;
                #1;
                chk("alt_wait0", m0_waitrequest, (i % 2 == 1));
                chk("alt_wait1", m1_waitrequest, (i % 2 == 0));
                step();
            end else begin
                idle();
            end
        end
        chk("alt_cnt0", p0, 3);
        chk("alt_cnt1", p1, 3);

        // Partial write by m1, then read back by m0
        m1_address = 13'd100; m1_write = 1;
        m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;
        #1;
        chk("wr_wait1", m1_waitrequest, 0);
        chk("wr_ramwr", ram_write, 1);
        step();
        idle();
        chk("wr_rdv1", m1_readdatavalid, 0);
        m0_address = 13'd100; m0_read = 1;
        #1;
        chk("wrb_wait0", m0_waitrequest, 0);
        step();
        idle();
        chk("wrb_data", m0_readdata, 32'hAAAA5678);

        // Out-of-range write and read
        m0_address = 13'd4134; m0_write = 1; m0_writedata = 32'hFFFFFFFF;
        #1;
        chk("oor_wait0", m0_waitrequest, 0);
        chk("oor_cs", ram_chipselect, 0);
        chk("oor_wr", ram_write, 0);
        step();
        idle();
        chk("oor_flag", err_oor, 1);
        m1_address = 13'd4200; m1_read = 1;
        #1;
        chk("oorr_wait1", m1_waitrequest, 0);
        chk("oorr_cs", ram_chipselect, 0);
        step();
        idle();
        chk("oorr_rdv1", m1_readdatavalid, 1);
        chk("oorr_d1", m1_readdata, 0);
        m0_address = 13'd4133; m0_read = 1;
        #1;
        chk("last_cs", ram_chipselect, 1);
        step();
        idle();
        chk("last_d0", m0_readdata, 32'h0BADF00D);
        err_clr = 1; m1_address = 13'd8191; m1_read = 1;
        step();
        idle(); err_clr = 0;
        chk("clr_setwin", err_oor, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("clr_oor", err_oor, 0);

        // Lock held past LOCK_MAX is forcibly released
        do_reset();
        m0_address = 13'd5;   m0_read = 1; m0_lock = 1;
        m1_address = 13'd100; m1_read = 1;
        #1;
        chk("lk0_wait0", m0_waitrequest, 0);
        chk("lk0_wait1", m1_waitrequest, 1);
        step();
        for (int k = 1; k <= 16; k++) begin
            chk("lk_blk1", m1_waitrequest, 1);
            chk("lk_own0", m0_waitrequest, 0);
            chk("lk_to_early", err_lock_to, 0);
            step();
        end
        chk("lk_to", err_lock_to, 1);
        chk("lk_rel1", m1_waitrequest, 0);
        chk("lk_rel0", m0_waitrequest, 1);
        chk("lk_inflight", m0_readdatavalid, 1);
        chk("lk_inflight_d", m0_readdata, 32'hDEADBEEF);
        step();
        idle();
        chk("lk_rdv1", m1_readdatavalid, 1);
        chk("lk_d1", m1_readdata, 32'h12345678 & 32'h0000FFFF | 32'hAAAA0000);

        // Reset asserted while a read return is pending
        step();
        m0_address = 13'd5; m0_read = 1;
        #1;
        chk("mr_wait0", m0_waitrequest, 0);
        step();
        idle();
        reset_n = 1'b0;
        #1;
        chk("mr_rdv0", m0_readdatavalid, 0);
        chk("mr_d0", m0_readdata, 0);
        chk("mr_lto", err_lock_to, 0);
        chk("mr_cs", ram_chipselect, 0);
        chk("mr_wait1", m1_waitrequest, 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        chk("mr_post_rdv0", m0_readdatavalid, 0);
        m0_address = 13'd5; m0_read = 1;
        m1_address = 13'd100; m1_read = 1;
        #1;
        chk("mr_tie0", m0_waitrequest, 0);
        chk("mr_tie1", m1_waitrequest, 1);
        step();
        idle();
        chk("mr_tie_rdv0", m0_readdatavalid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the second (s2) port of the 32-bit instruction memory between two Avalon-MM requesters (m0: boot loader/DMA, m1: debug/monitor master).
- Round-robin arbitration, one transfer per cycle, optional lock for atomic sequences with timeout.
- Out-of-range address protection; fixed 1-cycle read latency toward the requesters.

Parameters:
- ADDR_W, 13, word address width of the memory port
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 4134, number of valid words; addresses >= DEPTH are out of range
- LOCK_MAX, 16, maximum cycles a lock may be held before forced release

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- mN_address  in  ADDR_W  word address, N = 0,1
- mN_byteenable  in  DATA_W/8  byte lanes for writes
- mN_read / mN_write  in  1  transfer request
- mN_writedata  in  DATA_W  write data
- mN_lock  in  1  keep grant after this transfer
- mN_waitrequest  out  1  high = transfer not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  read data valid
- ram_address  out  ADDR_W
- ram_byteenable  out  DATA_W/8
- ram_chipselect  out  1
- ram_write  out  1
- ram_writedata  out  DATA_W
- ram_readdata  in  DATA_W  unregistered memory output, valid the cycle after address
- err_clr  in  1  clears sticky error flags
- err_oor  out  1  sticky: out-of-range access seen
- err_lock_to  out  1  sticky: lock timeout occurred

Behaviour:
- Reset (async, reset_n=0):
  - last_grant=1, so m0 wins the first tie.
  - Lock, lock counter and read-pending flags cleared.
  - All readdatavalid=0, err_oor=0, err_lock_to=0, ram_chipselect=0, ram_write=0.
- Request = read|write. read&write together is treated as a write; the read is ignored.
- Grant is combinational in the same cycle:
  - Locked: only the lock owner may be granted.
  - Else, one requester: that requester wins.
  - Else, both requesting: the port != last_grant wins.
  - last_grant updates on every accepted transfer.
- Winner: waitrequest=0 and its signals drive ram_*. Loser and idle ports: waitrequest=1. Idle ports never see waitrequest=0 spuriously.
- Throughput: one accepted transfer per cycle; back-to-back reads and writes are allowed with no bubbles.
- Read latency: read accepted in cycle T → mN_readdatavalid=1 in T+1 (registered), mN_readdata=ram_readdata in T+1. readdata is 0 when readdatavalid=0.
- Out of range (address >= DEPTH):
  - Transfer is accepted (waitrequest=0) but ram_chipselect=0; writes are dropped.
  - Reads return readdatavalid=1 with readdata=0 in T+1.
  - err_oor set next edge.
- Lock:
  - Accepted transfer with lock=1 sets lock owner = that port and resets lock_cnt to 0.
  - Accepted transfer by the owner with lock=0 releases the lock after that transfer.
  - lock_cnt increments every locked cycle; on reaching LOCK_MAX the lock is forcibly released and err_lock_to is set.
  - A forced release does not abort an in-flight read.
- err_clr clears both sticky flags; a set in the same cycle wins over clear.
- Idle cycles: ram_chipselect=0, ram_write=0; ram_address holds its last value (don't care).
- Reset mid-read: pending readdatavalid is lost; no stale data after reset release.

Decomposition:
- Package imem_arb_pkg: ADDR_W, DATA_W, DEPTH constants and a port-index typedef (1 bit).
- One natural sub-module, imem_rr_arb2: 2-way round-robin grant with lock override and lock timeout counter.
- Mux, range check and read-return pipeline stay in the top.

Test Plan:
- m0 reads addr 5 alone (mem[5]=0xDEADBEEF) → m0_waitrequest=0 in T; m0_readdatavalid=1, m0_readdata=0xDEADBEEF in T+1; m1 sees nothing.
- m0 and m1 both read continuously for 6 cycles from reset → grants alternate m0,m1,m0,m1,m0,m1; each gets 3 readdatavalid pulses 1 cycle after acceptance.
- m1 writes 0x12345678, byteenable=4'b0011 to addr 100, then m0 reads 100 (old 0xAAAAAAAA) → m0 readdata=0xAAAA5678.
- m0 writes to addr 4134 → accepted, ram_chipselect=0, err_oor=1 next cycle; m1 read 4200 → readdatavalid with 0; err_clr → err_oor=0.
- m0 lock=1 then keeps requesting with lock=1 while m1 requests, LOCK_MAX=16 → m1 blocked 16 cycles, then lock forced off, err_lock_to=1, m1 granted next tie.
- Assert reset_n low the cycle after an accepted read → no readdatavalid; all outputs at reset values; m0 wins the first tie after release.
